// File: rtl/dds_write_scheduler.sv
// DDS write scheduler: arbitrates frequency/phase/amplitude FIFO heads
// round-robin, issues one command at a time to the DDS serial engine, and pops
// the FIFO head only after the engine reports completion (or after a timeout).
//
// Handshake: a FIFO head is offered while its dv_in is high and is consumed by
// a one-cycle rd_out pulse, issued only in ACK. The engine receives a
// one-cycle cmd_dv_out strobe with cmd_type_out/cmd_data_out held stable
// until the scheduler returns to IDLE. It answers with a one-cycle
// cmd_done_in, which is looked at only while waiting.
module dds_write_scheduler #(
  parameter int W_FREQ  = 48,
  parameter int W_PHASE = 14,
  parameter int W_AMP   = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              freq_dv_in,
  input  logic [W_FREQ-1:0] freq_data_in,
  input  logic              phase_dv_in,
  input  logic [W_PHASE-1:0] phase_data_in,
  input  logic              amp_dv_in,
  input  logic [W_AMP-1:0]  amp_data_in,
  output logic              freq_rd_out,
  output logic              phase_rd_out,
  output logic              amp_rd_out,
  output logic              cmd_dv_out,
  output logic [1:0]        cmd_type_out,
  output logic [W_FREQ-1:0] cmd_data_out,
  input  logic              cmd_done_in,
  output logic              busy_out,
  output logic              timeout_out,
  output logic [1:0]        state_dbg_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [1:0]  SRC_FREQ  = 2'd0;
  localparam logic [1:0]  SRC_PHASE = 2'd1;
  localparam logic [1:0]  SRC_AMP   = 2'd2;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          type_q, type_d;
  logic [W_FREQ-1:0]   data_q, data_d;
  logic                cmd_dv_q, cmd_dv_d;
  logic [2:0]          rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                to_q, to_d;

  logic [3:0]          req;
  logic [1:0]          cand1, cand2, cand3;
  logic                grant_found;
  logic [1:0]          grant_src;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_AMP) ? SRC_FREQ : s + 2'd1;
  endfunction

  // Round-robin pick: search starts at the source after the last grant.
  always_comb begin
    req         = {1'b0, amp_dv_in, phase_dv_in, freq_dv_in};
    cand1       = next_src(ptr_q);
    cand2       = next_src(cand1);
    cand3       = next_src(cand2);
    grant_found = 1'b0;
    grant_src   = SRC_FREQ;
    if (req[cand1]) begin
      grant_found = 1'b1;
      grant_src   = cand1;
    end else if (req[cand2]) begin
      grant_found = 1'b1;
      grant_src   = cand2;
    end else if (req[cand3]) begin
      grant_found = 1'b1;
      grant_src   = cand3;
    end
  end

  // Next-state and next-output logic; every output is the image of a register.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    data_d   = data_q;
    cmd_dv_d = 1'b0;
    rd_d     = 3'b000;
    to_d     = to_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_ISSUE;
          ptr_d   = grant_src;
          type_d  = grant_src;
          data_d  = '0;
          case (grant_src)
            SRC_PHASE: data_d[W_PHASE-1:0] = phase_data_in;
            SRC_AMP:   data_d[W_AMP-1:0]   = amp_data_in;
            default:   data_d              = freq_data_in;
          endcase
        end
      end
      S_ISSUE: begin
        state_d  = S_WAIT;
        cmd_dv_d = 1'b1;
        cnt_d    = '0;
      end
      S_WAIT: begin
        if (cmd_done_in) begin
          state_d = S_ACK;
          rd_d    = 3'b001 << type_q;
        end else if (cnt_q == WAIT_LAST) begin
          // Engine never answered: drop the word so the queue keeps moving.
          state_d = S_ACK;
          rd_d    = 3'b001 << type_q;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACK: begin
        // One idle turnaround lets the popped FIFO refresh its valid.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      ptr_q    <= SRC_AMP;
      cnt_q    <= '0;
      type_q   <= '0;
      data_q   <= '0;
      cmd_dv_q <= 1'b0;
      rd_q     <= 3'b000;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      data_q   <= data_d;
      cmd_dv_q <= cmd_dv_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
    end
  end

  assign freq_rd_out   = rd_q[0];
  assign phase_rd_out  = rd_q[1];
  assign amp_rd_out    = rd_q[2];
  assign cmd_dv_out    = cmd_dv_q;
  assign cmd_type_out  = type_q;
  assign cmd_data_out  = data_q;
  assign busy_out      = busy_q;
  assign timeout_out   = to_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_dds_write_scheduler.sv
// Bench for dds_write_scheduler: FIFO heads modelled as queues, a simple DDS
// engine answering after a set delay, and a scoreboard of expected commands.
// A second instance with TIMEOUT=8 exercises the abort path.
module tb_dds_write_scheduler;

  localparam int SBW = 50;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        freq_dv_in = 1'b0, phase_dv_in = 1'b0, amp_dv_in = 1'b0;
  logic [47:0] freq_data_in = '0;
  logic [13:0] phase_data_in = '0;
  logic [9:0]  amp_data_in = '0;
  logic        cmd_done_in = 1'b0;

  logic        freq_rd_out, phase_rd_out, amp_rd_out, cmd_dv_out, busy_out, timeout_out;
  logic [1:0]  cmd_type_out, state_dbg_out;
  logic [47:0] cmd_data_out;

  logic        to_freq_rd, to_phase_rd, to_amp_rd, to_cmd_dv, to_busy, to_timeout;
  logic [1:0]  to_cmd_type, to_state;
  logic [47:0] to_cmd_data;

  dds_write_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .freq_dv_in(freq_dv_in), .freq_data_in(freq_data_in),
    .phase_dv_in(phase_dv_in), .phase_data_in(phase_data_in),
    .amp_dv_in(amp_dv_in), .amp_data_in(amp_data_in),
    .freq_rd_out(freq_rd_out), .phase_rd_out(phase_rd_out), .amp_rd_out(amp_rd_out),
    .cmd_dv_out(cmd_dv_out), .cmd_type_out(cmd_type_out), .cmd_data_out(cmd_data_out),
    .cmd_done_in(cmd_done_in), .busy_out(busy_out), .timeout_out(timeout_out),
    .state_dbg_out(state_dbg_out)
  );

  dds_write_scheduler #(.TIMEOUT(8)) dut_to (
    .clk_in(clk_in), .rst_in(rst_in),
    .freq_dv_in(freq_dv_in), .freq_data_in(freq_data_in),
    .phase_dv_in(phase_dv_in), .phase_data_in(phase_data_in),
    .amp_dv_in(amp_dv_in), .amp_data_in(amp_data_in),
    .freq_rd_out(to_freq_rd), .phase_rd_out(to_phase_rd), .amp_rd_out(to_amp_rd),
    .cmd_dv_out(to_cmd_dv), .cmd_type_out(to_cmd_type), .cmd_data_out(to_cmd_data),
    .cmd_done_in(cmd_done_in), .busy_out(to_busy), .timeout_out(to_timeout),
    .state_dbg_out(to_state)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  logic [SBW-1:0] exp_q[$];
  logic [47:0] fq[$];
  logic [13:0] pq[$];
  logic [9:0]  aq[$];

  logic        eng_en = 1'b0;
  int          eng_lat = 5;
  int          dcnt = 0;
  logic        use_to = 1'b0;
  logic        in_txn = 1'b0;
  logic [SBW-1:0] last_cmd = '0;
  int          cyc = 0;
  int          last_cmd_cyc = -1;
  logic        spacing_en = 1'b0;
  int          exp_spacing = 0;
  int          n_rd_f = 0, n_rd_p = 0, n_rd_a = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_fifos();
    freq_dv_in    = (fq.size() != 0);
    freq_data_in  = (fq.size() != 0) ? fq[0] : '0;
    phase_dv_in   = (pq.size() != 0);
    phase_data_in = (pq.size() != 0) ? pq[0] : '0;
    amp_dv_in     = (aq.size() != 0);
    amp_data_in   = (aq.size() != 0) ? aq[0] : '0;
  endtask

  // One clock: sample #1 after the edge, score, model FIFOs and engine.
  task automatic step();
    logic fr, pr, ar;
    logic [SBW-1:0] obs, expv;
    @(posedge clk_in);
    #1;
    cyc++;
    chk("rd_onehot", 64'(int'(freq_rd_out) + int'(phase_rd_out) + int'(amp_rd_out) <= 1), 64'd1);
    if (cmd_dv_out) begin
      obs = {cmd_type_out, cmd_data_out};
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        chk("sb_cmd", 64'(obs), 64'(expv));
      end
      if (spacing_en && last_cmd_cyc >= 0)
        chk("cmd_spacing", 64'(cyc - last_cmd_cyc), 64'(exp_spacing));
      last_cmd_cyc = cyc;
      last_cmd = obs;
      in_txn = 1'b1;
    end else if (in_txn && busy_out) begin
      chk("cmd_hold", 64'({cmd_type_out, cmd_data_out}), 64'(last_cmd));
    end
    if (!busy_out) in_txn = 1'b0;
    fr = use_to ? to_freq_rd  : freq_rd_out;
    pr = use_to ? to_phase_rd : phase_rd_out;
    ar = use_to ? to_amp_rd   : amp_rd_out;
    if (freq_rd_out)  n_rd_f++;
    if (phase_rd_out) n_rd_p++;
    if (amp_rd_out)   n_rd_a++;
    if (fr && fq.size() != 0) void'(fq.pop_front());
    if (pr && pq.size() != 0) void'(pq.pop_front());
    if (ar && aq.size() != 0) void'(aq.pop_front());
    if (eng_en) begin
      cmd_done_in = 1'b0;
      if (cmd_dv_out) dcnt = eng_lat;
      else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) cmd_done_in = 1'b1;
      end
    end
    drive_fifos();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    eng_en = 1'b0;
    cmd_done_in = 1'b0;
    dcnt = 0;
    step();
    rst_in = 1'b1;
    in_txn = 1'b0;
    last_cmd_cyc = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy_out), 64'd0);
    chk({tag, "_cmd_dv"}, 64'(cmd_dv_out), 64'd0);
    chk({tag, "_type"}, 64'(cmd_type_out), 64'd0);
    chk({tag, "_data"}, 64'(cmd_data_out), 64'd0);
    chk({tag, "_rd"}, 64'({freq_rd_out, phase_rd_out, amp_rd_out}), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_out), 64'd0);
  endtask

  initial begin
    int k;
    logic found;
    int to_cmd_s, to_rd_s, to_to_s, to_rd_n;
    logic to_busy_after, to_sticky;

    // Reset state
    rst_in = 1'b0;
    drive_fifos();
    step();
    step();
    chk_all_zero("reset");
    chk("reset_to_timeout", 64'(to_timeout), 64'd0);
    rst_in = 1'b1;

    // Freq only: 2-clock latency, done 10 clocks after the strobe
    eng_en = 1'b1;
    eng_lat = 10;
    fq.push_back(48'h1234_5678_9ABC);
    exp_q.push_back({2'd0, 48'h1234_5678_9ABC});
    drive_fifos();
    step();
    chk("t1_lat1_cmd_dv", 64'(cmd_dv_out), 64'd0);
    chk("t1_lat1_busy", 64'(busy_out), 64'd1);
    step();
    chk("t1_lat2_cmd_dv", 64'(cmd_dv_out), 64'd1);
    k = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      k++;
      if (freq_rd_out || phase_rd_out || amp_rd_out) found = 1'b1;
    end
    chk("t1_rd_seen", 64'(found), 64'd1);
    chk("t1_rd_delay", 64'(k), 64'd11);
    chk("t1_rd_freq", 64'({freq_rd_out, phase_rd_out, amp_rd_out}), 64'b100);
    step();
    chk("t1_idle_busy", 64'(busy_out), 64'd0);
    chk("t1_fifo_empty", 64'(fq.size()), 64'd0);
    step();
    chk("t1_rd_count", 64'(n_rd_f), 64'd1);

    // All three valid, done after 5 clocks: strict rotation and spacing
    do_reset();
    n_rd_f = 0; n_rd_p = 0; n_rd_a = 0;
    eng_en = 1'b1;
    eng_lat = 5;
    spacing_en = 1'b1;
    exp_spacing = 9;
    fq = '{48'hAAAA_0000_0001, 48'hAAAA_0000_0002, 48'hFFFF_FFFF_FFFF};
    pq = '{14'h3FFF, 14'h0123, 14'h2000};
    aq = '{10'h3FF, 10'h155, 10'h001};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'd0, fq[i]});
      exp_q.push_back({2'd1, 34'd0, pq[i]});
      exp_q.push_back({2'd2, 38'd0, aq[i]});
    end
    drive_fifos();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (exp_q.size() == 0 && !busy_out) found = 1'b1;
    end
    spacing_en = 1'b0;
    chk("t2_done", 64'(found), 64'd1);
    chk("t2_pops_f", 64'(n_rd_f), 64'd3);
    chk("t2_pops_p", 64'(n_rd_p), 64'd3);
    chk("t2_pops_a", 64'(n_rd_a), 64'd3);
    chk("t2_fifos_empty", 64'(fq.size() + pq.size() + aq.size()), 64'd0);

    // Reset during phase WAIT: no pop, next grant is freq not amp
    do_reset();
    eng_en = 1'b1;
    eng_lat = 3;
    fq = '{48'h0000_1111_2222, 48'h0000_3333_4444};
    pq = '{14'h1ABC};
    aq = '{10'h2AA};
    exp_q.push_back({2'd0, 48'h0000_1111_2222});
    exp_q.push_back({2'd1, 34'd0, 14'h1ABC});
    drive_fifos();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (exp_q.size() == 0) found = 1'b1;
    end
    chk("t3_phase_issued", 64'(found), 64'd1);
    eng_en = 1'b0;
    cmd_done_in = 1'b0;
    dcnt = 0;
    step();
    step();
    chk("t3_in_wait_busy", 64'(busy_out), 64'd1);
    rst_in = 1'b0;
    step();
    chk_all_zero("t3_rst");
    rst_in = 1'b1;
    in_txn = 1'b0;
    chk("t3_phase_kept", 64'(pq.size()), 64'd1);
    exp_q.push_back({2'd0, 48'h0000_3333_4444});
    exp_q.push_back({2'd1, 34'd0, 14'h1ABC});
    exp_q.push_back({2'd2, 38'd0, 10'h2AA});
    eng_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (exp_q.size() == 0 && !busy_out) found = 1'b1;
    end
    chk("t3_drained", 64'(found), 64'd1);
    chk("t3_fifos_empty", 64'(fq.size() + pq.size() + aq.size()), 64'd0);

    // Done ignored in IDLE and ISSUE, honoured in WAIT
    eng_en = 1'b0;
    cmd_done_in = 1'b1;
    step();
    chk("t4_idle_done_busy", 64'(busy_out), 64'd0);
    chk("t4_idle_done_rd", 64'({freq_rd_out, phase_rd_out, amp_rd_out}), 64'd0);
    fq.push_back(48'h0BAD_CAFE_0001);
    exp_q.push_back({2'd0, 48'h0BAD_CAFE_0001});
    drive_fifos();
    step();
    chk("t4_issue_rd", 64'({freq_rd_out, phase_rd_out, amp_rd_out}), 64'd0);
    chk("t4_issue_busy", 64'(busy_out), 64'd1);
    step();
    chk("t4_wait_cmd_dv", 64'(cmd_dv_out), 64'd1);
    chk("t4_wait_rd", 64'({freq_rd_out, phase_rd_out, amp_rd_out}), 64'd0);
    cmd_done_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_still_busy", 64'(busy_out), 64'd1);
    chk("t4_not_popped", 64'(fq.size()), 64'd1);
    cmd_done_in = 1'b1;
    step();
    cmd_done_in = 1'b0;
    chk("t4_ack_rd", 64'({freq_rd_out, phase_rd_out, amp_rd_out}), 64'b100);
    step();
    chk("t4_back_idle", 64'(busy_out), 64'd0);
    chk("t4_popped", 64'(fq.size()), 64'd0);

    // Timeout on the TIMEOUT=8 instance; engine silent
    do_reset();
    use_to = 1'b1;
    fq.push_back(48'h0000_0000_0ABC);
    exp_q.push_back({2'd0, 48'h0000_0000_0ABC});
    drive_fifos();
    to_cmd_s = -1; to_rd_s = -1; to_to_s = -1; to_rd_n = 0;
    to_busy_after = 1'b1;
    to_sticky = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (to_cmd_dv && to_cmd_s < 0) to_cmd_s = i;
      if (to_freq_rd) begin
        to_rd_n++;
        if (to_rd_s < 0) to_rd_s = i;
      end
      if (to_timeout && to_to_s < 0) to_to_s = i;
      if (i == 11) to_busy_after = to_busy;
      if (i > 10 && !to_timeout) to_sticky = 1'b0;
    end
    chk("t5_cmd_step", 64'(to_cmd_s), 64'd2);
    chk("t5_rd_step", 64'(to_rd_s), 64'd10);
    chk("t5_timeout_step", 64'(to_to_s), 64'd10);
    chk("t5_single_pop", 64'(to_rd_n), 64'd1);
    chk("t5_idle_after", 64'(to_busy_after), 64'd0);
    chk("t5_sticky", 64'(to_sticky), 64'd1);
    chk("t5_main_no_timeout", 64'(timeout_out), 64'd0);
    chk("t5_main_waiting", 64'(busy_out), 64'd1);
    use_to = 1'b0;
    fq.delete();
    drive_fifos();
    do_reset();
    chk("t5_reset_clears", 64'(to_timeout), 64'd0);
    chk_all_zero("final_rst");
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_write_scheduler.md
DDS_WRITE_SCHEDULER -- requirements
Module: dds_write_scheduler

Interface
REQ-001 Parameter W_FREQ, default 48: frequency word width; also the width of cmd_data_out.
REQ-002 Parameter W_PHASE, default 14: phase word width; SHALL be <= W_FREQ.
REQ-003 Parameter W_AMP, default 10: amplitude word width; SHALL be <= W_FREQ.
REQ-004 Parameter TIMEOUT, default 4096: maximum WAIT cycles before abort; range 2..65535.
REQ-005 clk_in  input  1  single clock for the whole block, rising edge.
REQ-006 rst_in  input  1  reset: synchronous, active-low.
REQ-007 freq_dv_in  input  1  frequency FIFO head valid (first-word fall-through).
REQ-008 freq_data_in  input  W_FREQ  frequency FIFO head word.
REQ-009 phase_dv_in  input  1  phase FIFO head valid.
REQ-010 phase_data_in  input  W_PHASE  phase FIFO head word.
REQ-011 amp_dv_in  input  1  amplitude FIFO head valid.
REQ-012 amp_data_in  input  W_AMP  amplitude FIFO head word.
REQ-013 freq_rd_out, phase_rd_out, amp_rd_out  output  1 each  FIFO pop strobes, one-cycle pulses.
REQ-014 cmd_dv_out  output  1  one-cycle command strobe to the DDS serial engine.
REQ-015 cmd_type_out  output  2  command type: 0=freq, 1=phase, 2=amp; 3 is never driven.
REQ-016 cmd_data_out  output  W_FREQ  command word, zero-extended.
REQ-017 cmd_done_in  input  1  engine write-complete pulse.
REQ-018 busy_out  output  1  high in every state except IDLE.
REQ-019 timeout_out  output  1  sticky abort flag.

Function
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, WAIT and ACK; all outputs SHALL be registered.
REQ-021 In IDLE with any dv_in high, the FSM SHALL grant one source round-robin, latch its type and data, and go to ISSUE.
REQ-022 Grant order SHALL start at the source after the last granted one, in the cycle freq->phase->amp->freq.
REQ-023 After reset the last-grant pointer SHALL be amp, so freq has first priority.
REQ-024 In ISSUE, cmd_dv_out SHALL be high for exactly one cycle with the latched type and data, then the FSM SHALL go to WAIT.
- Latency from dv_in high in IDLE to cmd_dv_out high: 2 clocks.
REQ-025 cmd_type_out and cmd_data_out SHALL hold stable from ISSUE until the FSM returns to IDLE.
REQ-026 phase and amplitude data SHALL appear on cmd_data_out zero-extended to W_FREQ.
REQ-027 cmd_done_in SHALL be sampled only in WAIT; in any other state it SHALL be ignored.
REQ-028 On cmd_done_in in WAIT, the FSM SHALL go to ACK and pulse the granted source's rd_out for one cycle.
REQ-029 The FIFO head SHALL NOT be popped before done; this keeps a word present until it is written.
REQ-030 ACK SHALL last one cycle, then the FSM SHALL go to IDLE, so the FIFO valid can update before re-arbitration.
REQ-031 WAIT counter: cleared on entry to WAIT, incremented each WAIT cycle; at TIMEOUT-1 without done the FSM SHALL:
- set timeout_out,
- go to ACK and pop the word (drop it).
REQ-032 timeout_out SHALL clear only on reset.
REQ-033 At most one rd_out SHALL be high in any cycle, and only in ACK.
REQ-034 A dv_in that falls while its word is granted SHALL NOT abort the transaction; the latched word completes.
REQ-035 The ACK-to-IDLE turnaround gives a minimum spacing of 4 clocks between consecutive cmd_dv_out pulses plus the engine time.

Reset
REQ-036 With rst_in low at a clock edge, the block SHALL reset as follows:
- state=IDLE, pointer=amp, WAIT counter=0;
- all outputs 0, including cmd_type_out, cmd_data_out and timeout_out.
REQ-037 A reset mid-transaction SHALL abandon the command without a pop; the FIFO keeps the word.

Verification
REQ-038 Freq only: freq_dv_in=1, data 0x123456789ABC; done 10 clocks after cmd_dv_out -> cmd_dv_out 2 clocks after dv with type 0 and that data; single freq_rd_out in ACK.
REQ-039 All three valid continuously, each done after 5 clocks -> grants freq, phase, amp, freq...; phase 0x3FFF appears as 0x000000003FFF.
REQ-040 Timeout, TIMEOUT=8, no done -> after 8 WAIT cycles timeout_out=1, the source is popped, the FSM idles; timeout_out stays 1 until reset.
REQ-041 Reset during WAIT -> next cycle all outputs 0, no rd_out pulse; the next grant is freq even if the last grant was phase.
REQ-042 cmd_done_in pulsed in IDLE and ISSUE -> ignored, no pop; in WAIT -> pop, then return to IDLE.
